// File: rtl/mul16_pkg.sv
// mul16_pkg: shared FSM state type and sizing constants for the sequential 16x16 multiplier.
package mul16_pkg;
    localparam int MUL16_W     = 16;
    localparam int MUL16_STEPS = 16;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mul16_seq_adder.sv
// Adder16: 16-bit wrap-around adder; the carry out of bit 15 is discarded.
module Adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out
);
    assign out = a + b;
endmodule

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add 16x16 multiplier, low 16 bits of the product, valid/ready on both sides.
// Define MUL16_OVF_EN to add the ovf output (full product exceeds 0xFFFF).
module mul16_seq
    import mul16_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MUL16_W-1:0] a,
    input  logic [MUL16_W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MUL16_W-1:0] out
`ifdef MUL16_OVF_EN
    ,
    output logic               ovf
`endif
);
    state_t               state_q, state_d;
    logic [MUL16_W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d, sum;
    logic [4:0]           step_q, step_d;
    logic [2*MUL16_W-1:0] a_ext;
    logic                 bit_on;
`ifdef MUL16_OVF_EN
    logic                 ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;
`endif

    Adder16 u_add (.a(acc_q), .b(a_ext[MUL16_W-1:0]), .out(sum));

    assign a_ext     = {{MUL16_W{1'b0}}, a_q} << step_q[3:0];
    assign bit_on    = b_q[step_q[3:0]] & ~step_q[4];
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out       = res_q;
`ifdef MUL16_OVF_EN
    assign ovf       = ovf_q;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        res_d   = res_q;
`ifdef MUL16_OVF_EN
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                acc_d   = '0;
                step_d  = '0;
                state_d = BUSY;
`ifdef MUL16_OVF_EN
                ovf_acc_d = 1'b0;
                ovf_d     = 1'b0;
`endif
            end
            // steps 0..15 add partial products; step 16 commits the result
            BUSY: if (step_q == 5'(MUL16_STEPS)) begin
                res_d   = acc_q;
                state_d = DONE;
`ifdef MUL16_OVF_EN
                ovf_d   = ovf_acc_q;
`endif
            end else begin
                acc_d  = bit_on ? sum : acc_q;
                step_d = step_q + 5'd1;
`ifdef MUL16_OVF_EN
                // overflow iff a partial product loses bits or the running sum wraps
                ovf_acc_d = ovf_acc_q | (bit_on & ((|a_ext[2*MUL16_W-1:MUL16_W]) | (sum < acc_q)));
`endif
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            res_q   <= '0;
`ifdef MUL16_OVF_EN
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            res_q   <= res_d;
`ifdef MUL16_OVF_EN
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: directed vector table plus reset, backpressure and busy-input sequences for mul16_seq.
module tb_mul16_seq;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0, out;
    logic        in_ready, out_valid;
`ifdef MUL16_OVF_EN
    logic        ovf;
`endif
    int total = 0, bad = 0;

    typedef struct {
        logic [15:0] a, b, eo;
        logic        ev;
        int          hold;
    } vec_t;
    vec_t vecs[9];

    mul16_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
`ifdef MUL16_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_ovf(input string nm, input logic exp);
`ifdef MUL16_OVF_EN
        check(nm, 32'(ovf), 32'(exp));
`endif
    endtask

    // Drives one operand pair and hands the result off after 'hold' stalled DONE cycles.
    task automatic xact(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] eo,
                        input logic ev, input int hold, input bit noisy);
        int cyc = 0;
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = noisy;
        while (!out_valid && cyc < 40) begin
            if (noisy) begin a = 16'($urandom); b = 16'($urandom); end
            @(posedge clk); #1;
            cyc++;
            if (cyc < 17) check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        check("latency", 32'(cyc), 32'd17);
        check("out", 32'(out), 32'(eo));
        check_ovf("ovf", ev);
        check("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (noisy) begin a = 16'($urandom); b = 16'($urandom); end
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_out", 32'(out), 32'(eo));
            check_ovf("hold_ovf", ev);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out", 32'(out), 32'(eo));
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 0};
        vecs[2] = '{16'h0000, 16'hBEEF, 16'h0000, 1'b0, 1};
        vecs[3] = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 0};
        vecs[4] = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 5};
        vecs[5] = '{16'h1234, 16'h0010, 16'h2340, 1'b1, 0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 2};
        vecs[7] = '{16'h8000, 16'h0002, 16'h0000, 1'b1, 0};
        vecs[8] = '{16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 0};

        #12;
        check("rst_out", 32'(out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) xact(vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ev, vecs[i].hold, 1'b0);

        // reset mid-BUSY at step 8
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check_ovf("midrst_ovf", 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        xact(16'h0007, 16'h0006, 16'h002A, 1'b0, 0, 1'b0);

        // in_valid held with changing operands through BUSY and DONE
        xact(16'h0003, 16'h0005, 16'h000F, 1'b0, 3, 1'b1);
        check("noisy_still_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("noisy_next_accept", 32'(in_ready), 32'd0);
        check("noisy_out_kept", 32'(out), 32'h000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 SHALL have port `clk`, input, 1 bit: single clock, rising-edge.
REQ-003 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port `in_valid`, input, 1 bit: operand pair offered.
REQ-005 SHALL have port `in_ready`, output, 1 bit: block accepts operands.
REQ-006 SHALL have port `a`, input, 16 bits: multiplicand, unsigned.
REQ-007 SHALL have port `b`, input, 16 bits: multiplier, unsigned.
REQ-008 SHALL have port `out_valid`, output, 1 bit: result available.
REQ-009 SHALL have port `out_ready`, input, 1 bit: consumer takes the result.
REQ-010 SHALL have port `out`, output, 16 bits: low 16 bits of a*b.
REQ-011 SHALL have port `ovf`, output, 1 bit, present only under MUL16_OVF_EN: true product > 0xFFFF.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY and DONE, with IDLE after reset.
REQ-013 SHALL drive `in_ready` = 1 only in IDLE.
REQ-014 SHALL accept operands on a rising edge with in_valid & in_ready, then:
- latch a and b;
- clear the accumulator and the step counter;
- go to BUSY.
REQ-015 SHALL, in BUSY, process one multiplier bit per cycle, LSB first:
- if the bit is 1: acc <= acc + (a_reg << step), mod 2^16;
- if the bit is 0: acc is unchanged;
- step increments by 1 each cycle.
REQ-016 SHALL perform every accumulation with exactly 16-bit wrap-around arithmetic and discard the carry out of bit 15 from `out`.
REQ-017 SHALL run BUSY for exactly 16 cycles regardless of operand values (no early exit), then go to DONE.
- `out_valid` rises on the 17th rising edge after the accepting edge.
REQ-018 SHALL, in DONE, drive `out_valid` = 1 and `out` = acc.
- `out` and `ovf` hold stable while out_valid & !out_ready.
REQ-019 SHALL, in DONE with out_ready = 1 at a rising edge, go to IDLE.
- `out_valid` falls in the next cycle.
- `in_ready` rises in the next cycle; no new operands are accepted in the same cycle as result hand-off.
REQ-020 SHALL ignore `in_valid`, `a` and `b` while in BUSY or DONE.
REQ-021 SHALL, in IDLE, drive `out` = last delivered result (0 after reset) and `out_valid` = 0.
REQ-022 SHALL ignore `out_ready` outside DONE.

Reset
REQ-023 SHALL, on rst_n low at any time (including mid-BUSY or in DONE), immediately:
- force the state to IDLE;
- force out = 0x0000, out_valid = 0, in_ready = 1, ovf = 0;
- clear acc, step and the operand registers.
REQ-024 SHALL abandon any in-flight operation on reset with no result delivered; the first edge after deassertion may accept new operands.

Configuration
REQ-025 SHALL, when MUL16_OVF_EN is defined, implement `ovf`:
- `ovf` is set in DONE iff the full 32-bit product a*b exceeds 0xFFFF;
- it is valid and stable together with `out_valid`;
- it is cleared on acceptance of new operands.
REQ-026 SHALL, when MUL16_OVF_EN is undefined, omit the `ovf` port and its logic entirely; all other behaviour is identical.

Structure
REQ-027 SHALL place in package mul16_pkg:
- the FSM state typedef (IDLE/BUSY/DONE);
- constant MUL16_STEPS = 16;
- constant MUL16_W = 16.
REQ-028 SHALL perform the accumulation addition by instantiating the codebase's existing 16-bit adder block, Adder16 (ports a, b, out), as its one sub-module; no `+` operator is used on the datapath.

Verification
REQ-029 a=3, b=5 accepted -> out_valid after 17 cycles, out=0x000F, ovf=0.
REQ-030 a=0xFFFF, b=0x0001 -> out=0xFFFF, ovf=0; a=0x0000, b=0xBEEF -> out=0x0000, ovf=0.
REQ-031 a=0x0100, b=0x0100 -> out=0x0000, ovf=1; a=0x00FF, b=0x0101 -> out=0xFFFF, ovf=0.
REQ-032 Backpressure, out_ready=0 for 5 cycles in DONE:
- out/out_valid/ovf stay stable, in_ready=0;
- out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 rst_n pulsed low during BUSY step 8:
- outputs reset immediately with no out_valid;
- a new pair a=7, b=6 is then accepted and yields out=0x002A.
REQ-034 in_valid held high with changing a/b throughout BUSY -> the original result is unaffected; the next acceptance occurs only after the DONE hand-off.
